// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-lite control FSM with memory handshake,
// extended branch/link ops and N/V status capture.
module mips_multicycle_ctrl #(
  parameter bit ENABLE_EXT    = 1'b1,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       alu_neg,
  input  logic       status_n,
  input  logic       status_v,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       status_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_BLEZAL    = 4'd11,
    S_BRV       = 4'd12,
    S_JMXOR     = 4'd13,
    S_JLINK     = 4'd14,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_NOR   = 2'b11;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   rdy;

  logic is_r, is_lw, is_sw, is_beq;
  logic is_nori, is_baln, is_blezal, is_jalpc;
  logic is_jmxor, is_brv, is_r_plain, is_jlink;

  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

  assign is_r       = opcode == 6'h00;
  assign is_lw      = opcode == 6'h23;
  assign is_sw      = opcode == 6'h2B;
  assign is_beq     = opcode == 6'h04;
  assign is_nori    = ENABLE_EXT && opcode == 6'h0E;
  assign is_baln    = ENABLE_EXT && opcode == 6'h1B;
  assign is_blezal  = ENABLE_EXT && opcode == 6'h1C;
  assign is_jalpc   = ENABLE_EXT && opcode == 6'h1E;
  assign is_jmxor   = ENABLE_EXT && is_r && funct == 6'h13;
  assign is_brv     = ENABLE_EXT && is_r && funct == 6'h14;
  assign is_r_plain = is_r && funct != 6'h13 && funct != 6'h14;
  assign is_jlink   = is_baln || is_jalpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 2'd0;
    mem_to_reg   = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 3'd0;
    alu_op       = OP_ADD;
    status_write = 1'b0;
    instr_done   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 3'd1;
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 3'd3;
        unique case (1'b1)
          is_lw || is_sw: state_d = S_MEM_ADDR;
          is_r_plain:     state_d = S_R_EXEC;
          is_beq:         state_d = S_BRANCH;
          is_nori:        state_d = S_I_EXEC;
          is_blezal:      state_d = S_BLEZAL;
          is_brv:         state_d = S_BRV;
          is_jmxor:       state_d = S_JMXOR;
          is_jlink:       state_d = S_JLINK;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd2;
        state_d   = is_lw ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy)
          state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a    = 1'b1;
        alu_op       = OP_FUNCT;
        status_write = 1'b1;
        state_d      = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 3'd4;
        alu_op       = OP_NOR;
        status_write = 1'b1;
        state_d      = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = OP_SUB;
        pc_src     = 2'd1;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BLEZAL: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd5;
        alu_op    = OP_SUB;
        if (zero || alu_neg) begin
          pc_src     = 2'd1;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'd3;
          mem_to_reg = 2'd2;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRV: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 3'd5;
        pc_write   = status_v;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JMXOR: begin
        alu_src_a  = 1'b1;
        alu_op     = OP_FUNCT;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JLINK: begin
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        // Link writes $31 with the PC register, which already holds PC+4
        if (is_baln) begin
          pc_src    = 2'd2;
          pc_write  = status_n;
          reg_write = status_n;
        end else begin
          pc_src    = 2'd1;
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      status_write = 1'b0;
      instr_done   = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multi-cycle control unit for the MIPS-lite datapath, replacing the single-cycle combinational decoder.
- FSM sequences fetch/decode/execute/memory/writeback over several clocks with a `mem_ready` handshake on the shared memory.
- Keeps the extended ISA: jmxor, brv, baln, blezal, jalpc, nori, with N/V status-flag capture.
- Sits between the instruction register and the datapath multiplexers, register file, PC and memory.

Parameters:
- ENABLE_EXT, 1, 1 = extended opcodes legal; 0 = they decode as illegal.
- USE_MEM_READY, 1, 1 = memory states wait for `mem_ready`; 0 = `mem_ready` is treated as constant 1.

Ports:
- clk in 1 system clock, all state changes on rising edge
- reset in 1 synchronous, active-high
- opcode in 6 IR[31:26], stable from DECODE onward
- funct in 6 IR[5:0]
- zero in 1 ALU zero
- alu_neg in 1 ALU result bit 31
- status_n in 1 registered N flag
- status_v in 1 registered V flag
- mem_ready in 1 memory access completes this cycle
- pc_write out 1 PC load enable
- pc_src out 2 0=ALU result, 1=ALUOut reg, 2={PC[31:28],IR[25:0],00}
- ir_write out 1 instruction register load
- i_or_d out 1 0=PC address, 1=ALUOut address
- mem_read out 1 memory read request
- mem_write out 1 memory write request
- reg_write out 1 register file write
- reg_dst out 2 0=rt, 1=rd, 2=$31, 3=$25
- mem_to_reg out 2 0=ALUOut, 1=MDR, 2=PC
- alu_src_a out 1 0=PC, 1=A reg
- alu_src_b out 3 0=B, 1=const 4, 2=sext imm, 3=sext imm<<2, 4=zext imm, 5=zero
- alu_op out 2 00=add, 01=sub, 10=by funct, 11=nor
- status_write out 1 N/V/Z capture enable
- instr_done out 1 one-cycle pulse in final state of each instruction
- illegal out 1 sticky illegal-opcode flag
- state out 4 current state encoding, for debug

Behaviour:
- Reset (synchronous, active-high): state<=FETCH, illegal<=0. While reset is high, every write/enable output is forced 0 (pc_write, ir_write, mem_read, mem_write, reg_write, status_write, instr_done). A reset mid-instruction aborts with no further writes.
- Outputs not listed for a state default to 0. Outputs are decoded from state plus registered inputs.
- Opcodes: R=00, lw=23, sw=2B, beq=04, nori=0E, baln=1B, blezal=1C, jalpc=1E (hex). Inside R-type: funct 13=jmxor, funct 14=brv; any other funct is a plain ALU R-op.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0. ir_write and pc_write assert only when mem_ready=1, and the FSM then goes to DECODE; otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, add (ALUOut<=branch target). Dispatch:
  - lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; nori -> I_EXEC
  - blezal -> BLEZAL; brv -> BRV; jmxor -> JMXOR; baln/jalpc -> JLINK
  - anything else -> ILLEGAL
- MEM_ADDR: src_a=1, src_b=2, add; then MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, done.
- MEM_WRITE: mem_write=1, i_or_d=1; held until mem_ready, then done.
- R_EXEC: src_a=1, src_b=0, alu_op=funct, status_write=1, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, done.
- I_EXEC: src_a=1, src_b=4, nor, status_write=1, then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, done.
- BRANCH: src_a=1, src_b=0, sub, pc_src=1, pc_write=zero, done.
- BLEZAL: src_a=1, src_b=5, sub. taken=zero|alu_neg. When taken: pc_src=1, pc_write=1, reg_write=1, reg_dst=3, mem_to_reg=2. Done.
- BRV: src_a=1, src_b=5, add, pc_src=0, pc_write=status_v, done.
- JMXOR: src_a=1, src_b=0, alu_op=funct (xor), pc_src=0, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2, done.
- JLINK:
  - baln: pc_src=2, pc_write=status_n, reg_write=status_n, reg_dst=2, mem_to_reg=2.
  - jalpc: pc_src=1, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2.
  - Done.
- Link value: the PC register already holds PC+4, and the register file samples it on the same edge that loads the new PC.
- "Done" means instr_done=1 and next state FETCH.
- ILLEGAL: illegal<=1; no enables; remains in ILLEGAL until reset.
- Latencies with mem_ready=1:
  - beq, brv, blezal, jmxor, baln, jalpc: 3 cycles
  - R-type, nori, sw: 4 cycles
  - lw: 5 cycles
  - Each cycle mem_ready is low adds exactly one cycle.

Test Plan:
- Reset held 2 cycles mid-MEM_WRITE -> mem_write=0 during reset; state=FETCH after release; illegal=0.
- add (opcode 00, funct 20) with mem_ready=1 -> instr_done on cycle 4; reg_write=1 with reg_dst=1 only in R_WB; status_write only in R_EXEC.
- lw with mem_ready low for 3 cycles in MEM_READ -> FSM stays 3 extra cycles; done on cycle 8; reg_write with mem_to_reg=1 once.
- beq zero=0 then zero=1 -> pc_write 0 then 1, pc_src=1; both done in 3 cycles.
- baln with status_n=0 then 1 -> no PC/reg write, then pc_src=2, pc_write=1, reg_write=1, reg_dst=2.
- blezal with alu_neg=1 -> reg_dst=3, mem_to_reg=2, pc_write=1. With ENABLE_EXT=0 -> ILLEGAL, illegal=1, no enables until reset.
